// File: rtl/attn_head_top.sv
// Single attention-head wrapper: head scratch memory, config latches, beat-to-vlink sequencer.
// Optional: define HEAD_KV_CLEAN_EN to enable per-user KV valid bits and clean_kv_cache.
module attn_head_top #(
    parameter int unsigned HEAD_MEM_DEPTH = 1024,
    parameter int unsigned LANES          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clean_kv_cache,
    input  logic [1:0]            clean_kv_cache_user_id,
    input  logic [18:0]           head_mem_addr,
    input  logic [15:0]           head_mem_wdata,
    input  logic                  head_mem_wen,
    input  logic                  head_mem_ren,
    output logic [15:0]           head_mem_rdata,
    output logic                  head_mem_rvld,
    input  logic [127:0]          global_sram_rd_data,
    input  logic                  global_sram_rd_data_vld,
    input  logic [LANES*128-1:0]  vlink_data_in_array,
    input  logic [LANES-1:0]      vlink_data_in_vld_array,
    output logic [LANES*128-1:0]  vlink_data_out_array,
    output logic [LANES-1:0]      vlink_data_out_vld_array,
    input  logic [31:0]           control_state,
    input  logic                  control_state_update,
    input  logic                  start,
    output logic                  finish,
    input  logic                  op_cfg_vld,
    input  logic [40:0]           op_cfg,
    input  logic                  usr_cfg_vld,
    input  logic [11:0]           usr_cfg,
    input  logic                  model_cfg_vld,
    input  logic [29:0]           model_cfg,
    input  logic                  pmu_cfg_vld,
    input  logic [3:0]            pmu_cfg,
    input  logic                  rc_cfg_vld,
    input  logic [83:0]           rc_cfg,
    output logic [18:0]           gbus_addr_delay1,
    output logic                  gbus_wen_delay1,
    output logic [31:0]           gbus_wdata_delay1
);
    localparam int unsigned ADDR_W     = $clog2(HEAD_MEM_DEPTH);
    localparam int unsigned LANE_W     = 128;
    localparam int unsigned LANE_IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e              state_q, state_d;
    logic                finish_q, finish_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [7:0]          n_q, n_d;
    logic                beat_acc_c;
    logic [40:0]         op_cfg_q, op_cfg_d;
    logic [11:0]         usr_cfg_q, usr_cfg_d;
    logic [29:0]         model_cfg_q, model_cfg_d;
    logic [3:0]          pmu_cfg_q, pmu_cfg_d;
    logic [83:0]         rc_cfg_q, rc_cfg_d;
    logic [31:0]         cs_q, cs_d, cs_eff_c;
    logic [15:0]         rdata_q, rdata_d;
    logic                rvld_q, rvld_d;
    logic [18:0]         gaddr_q, gaddr_d;
    logic                gwen_q, gwen_d;
    logic [31:0]         gwdata_q, gwdata_d;
    logic [LANES*128-1:0] vdata_q, vdata_d;
    logic [LANES-1:0]    vvld_q, vvld_d;
    logic [15:0]         mem_q [HEAD_MEM_DEPTH];
    logic                addr_ok_c, mem_we_c, kv_ok_c;
    logic [ADDR_W-1:0]   mem_idx_c;

    assign addr_ok_c = (head_mem_addr[18:ADDR_W] == '0);
    assign mem_idx_c = head_mem_addr[ADDR_W-1:0];
    assign mem_we_c  = head_mem_wen && addr_ok_c;

`ifdef HEAD_KV_CLEAN_EN
    logic [3:0] kv_vld_q, kv_vld_d;
    logic [1:0] region_c;
    assign region_c = head_mem_addr[ADDR_W-1 -: 2];
    assign kv_ok_c  = kv_vld_q[region_c];

    // Clean is applied after the write-set so it wins on a same-cycle collision.
    always_comb begin
        kv_vld_d = kv_vld_q;
        if (mem_we_c)       kv_vld_d[region_c] = 1'b1;
        if (clean_kv_cache) kv_vld_d[clean_kv_cache_user_id] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) kv_vld_q <= '0;
        else        kv_vld_q <= kv_vld_d;
    end
`else
    logic unused_kv;
    assign unused_kv = ^{clean_kv_cache, clean_kv_cache_user_id};
    assign kv_ok_c   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[mem_idx_c] <= head_mem_wdata;
    end

    // Config latches, host read path and gbus echo.
    always_comb begin
        op_cfg_d    = op_cfg_vld    ? op_cfg    : op_cfg_q;
        usr_cfg_d   = usr_cfg_vld   ? usr_cfg   : usr_cfg_q;
        model_cfg_d = model_cfg_vld ? model_cfg : model_cfg_q;
        pmu_cfg_d   = pmu_cfg_vld   ? pmu_cfg   : pmu_cfg_q;
        rc_cfg_d    = rc_cfg_vld    ? rc_cfg    : rc_cfg_q;
        cs_d        = control_state_update ? control_state : cs_q;
        cs_eff_c    = cs_d;
        rdata_d     = rdata_q;
        rvld_d      = 1'b0;
        if (head_mem_ren && !head_mem_wen) begin
            rvld_d  = 1'b1;
            rdata_d = (addr_ok_c && kv_ok_c) ? mem_q[mem_idx_c] : 16'h0;
        end
        gwen_d   = head_mem_wen;
        gaddr_d  = head_mem_wen ? head_mem_addr : gaddr_q;
        gwdata_d = head_mem_wen ? {16'h0, head_mem_wdata} : gwdata_q;
    end

    // Sequencer FSM.
    always_comb begin
        state_d    = state_q;
        finish_d   = finish_q;
        beat_cnt_d = beat_cnt_q;
        n_d        = n_q;
        beat_acc_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (cs_eff_c != '0)) begin
                    state_d    = ST_RUN;
                    finish_d   = 1'b0;
                    beat_cnt_d = '0;
                    n_d        = op_cfg_q[7:0];
                end
            end
            ST_RUN: begin
                if (beat_cnt_q == n_q) begin
                    state_d = ST_DONE;
                end else if (global_sram_rd_data_vld) begin
                    beat_acc_c = 1'b1;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                finish_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // vlink output: lane pass-through outside RUN, beat lane only inside RUN.
    always_comb begin
        vdata_d = vdata_q;
        vvld_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (state_q != ST_RUN) begin
                if (vlink_data_in_vld_array[i]) begin
                    vdata_d[i*LANE_W +: LANE_W] = vlink_data_in_array[i*LANE_W +: LANE_W];
                    vvld_d[i] = 1'b1;
                end
            end else if (beat_acc_c && (beat_cnt_q[LANE_IDX_W-1:0] == LANE_IDX_W'(i))) begin
                vdata_d[i*LANE_W +: LANE_W] = global_sram_rd_data;
                vvld_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            finish_q    <= 1'b0;
            beat_cnt_q  <= '0;
            n_q         <= '0;
            op_cfg_q    <= '0;
            usr_cfg_q   <= '0;
            model_cfg_q <= '0;
            pmu_cfg_q   <= '0;
            rc_cfg_q    <= '0;
            cs_q        <= '0;
            rdata_q     <= '0;
            rvld_q      <= 1'b0;
            gaddr_q     <= '0;
            gwen_q      <= 1'b0;
            gwdata_q    <= '0;
            vdata_q     <= '0;
            vvld_q      <= '0;
        end else begin
            state_q     <= state_d;
            finish_q    <= finish_d;
            beat_cnt_q  <= beat_cnt_d;
            n_q         <= n_d;
            op_cfg_q    <= op_cfg_d;
            usr_cfg_q   <= usr_cfg_d;
            model_cfg_q <= model_cfg_d;
            pmu_cfg_q   <= pmu_cfg_d;
            rc_cfg_q    <= rc_cfg_d;
            cs_q        <= cs_d;
            rdata_q     <= rdata_d;
            rvld_q      <= rvld_d;
            gaddr_q     <= gaddr_d;
            gwen_q      <= gwen_d;
            gwdata_q    <= gwdata_d;
            vdata_q     <= vdata_d;
            vvld_q      <= vvld_d;
        end
    end

    assign finish                   = finish_q;
    assign head_mem_rdata           = rdata_q;
    assign head_mem_rvld            = rvld_q;
    assign gbus_addr_delay1         = gaddr_q;
    assign gbus_wen_delay1          = gwen_q;
    assign gbus_wdata_delay1        = gwdata_q;
    assign vlink_data_out_array     = vdata_q;
    assign vlink_data_out_vld_array = vvld_q;
endmodule

// File: tb/tb_attn_head_top.sv
// Scoreboard bench for attn_head_top: host memory, config, sequencer and vlink paths.
module tb_attn_head_top;
    localparam int unsigned LANES = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clean_kv_cache;
    logic [1:0]           clean_kv_cache_user_id;
    logic [18:0]          head_mem_addr;
    logic [15:0]          head_mem_wdata;
    logic                 head_mem_wen, head_mem_ren;
    logic [15:0]          head_mem_rdata;
    logic                 head_mem_rvld;
    logic [127:0]         global_sram_rd_data;
    logic                 global_sram_rd_data_vld;
    logic [LANES*128-1:0] vlink_data_in_array, vlink_data_out_array;
    logic [LANES-1:0]     vlink_data_in_vld_array, vlink_data_out_vld_array;
    logic [31:0]          control_state;
    logic                 control_state_update, start, finish;
    logic                 op_cfg_vld, usr_cfg_vld, model_cfg_vld, pmu_cfg_vld, rc_cfg_vld;
    logic [40:0]          op_cfg;
    logic [11:0]          usr_cfg;
    logic [29:0]          model_cfg;
    logic [3:0]           pmu_cfg;
    logic [83:0]          rc_cfg;
    logic [18:0]          gbus_addr_delay1;
    logic                 gbus_wen_delay1;
    logic [31:0]          gbus_wdata_delay1;

    attn_head_top dut (
        .clk(clk), .rst_n(rst_n),
        .clean_kv_cache(clean_kv_cache), .clean_kv_cache_user_id(clean_kv_cache_user_id),
        .head_mem_addr(head_mem_addr), .head_mem_wdata(head_mem_wdata),
        .head_mem_wen(head_mem_wen), .head_mem_ren(head_mem_ren),
        .head_mem_rdata(head_mem_rdata), .head_mem_rvld(head_mem_rvld),
        .global_sram_rd_data(global_sram_rd_data), .global_sram_rd_data_vld(global_sram_rd_data_vld),
        .vlink_data_in_array(vlink_data_in_array), .vlink_data_in_vld_array(vlink_data_in_vld_array),
        .vlink_data_out_array(vlink_data_out_array), .vlink_data_out_vld_array(vlink_data_out_vld_array),
        .control_state(control_state), .control_state_update(control_state_update),
        .start(start), .finish(finish),
        .op_cfg_vld(op_cfg_vld), .op_cfg(op_cfg), .usr_cfg_vld(usr_cfg_vld), .usr_cfg(usr_cfg),
        .model_cfg_vld(model_cfg_vld), .model_cfg(model_cfg), .pmu_cfg_vld(pmu_cfg_vld), .pmu_cfg(pmu_cfg),
        .rc_cfg_vld(rc_cfg_vld), .rc_cfg(rc_cfg),
        .gbus_addr_delay1(gbus_addr_delay1), .gbus_wen_delay1(gbus_wen_delay1),
        .gbus_wdata_delay1(gbus_wdata_delay1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           lane;
        logic [127:0] data;
    } vexp_t;

    vexp_t       vq[$];
    logic [15:0] rq[$];
    int          total = 0;
    int          bad   = 0;
    logic        kv_en;
    logic [127:0] beat_base = 128'h12345678_9ABCDEF0_0FEDCBA9_87656978;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: pop and compare whenever the DUT produces a read or a vlink beat.
    always @(negedge clk) begin
        if (head_mem_rvld === 1'b1) begin
            if (rq.size() == 0) chk("rd_unexpected", 128'(head_mem_rdata), 128'hDEAD);
            else chk("rd_data", 128'(head_mem_rdata), 128'(rq.pop_front()));
        end
        for (int i = 0; i < LANES; i++) begin
            if (vlink_data_out_vld_array[i] === 1'b1) begin
                if (vq.size() == 0) begin
                    chk("vl_unexpected", 128'(i), 128'hFFFF);
                end else begin
                    vexp_t e;
                    e = vq.pop_front();
                    chk("vl_lane", 128'(i), 128'(e.lane));
                    chk("vl_data", vlink_data_out_array[i*128 +: 128], e.data);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        clean_kv_cache = 0; head_mem_wen = 0; head_mem_ren = 0;
        global_sram_rd_data_vld = 0; vlink_data_in_vld_array = '0;
        control_state_update = 0; start = 0; op_cfg_vld = 0;
        usr_cfg_vld = 0; model_cfg_vld = 0; pmu_cfg_vld = 0; rc_cfg_vld = 0;
    endtask

    task automatic wr(input logic [18:0] a, input logic [15:0] d);
        head_mem_addr = a; head_mem_wdata = d; head_mem_wen = 1;
        cyc(1);
        head_mem_wen = 0;
    endtask

    task automatic rd(input logic [18:0] a, input logic [15:0] exp);
        head_mem_addr = a; head_mem_ren = 1; rq.push_back(exp);
        cyc(1);
        head_mem_ren = 0;
    endtask

    task automatic set_n(input logic [7:0] n);
        op_cfg_vld = 1; op_cfg = 41'(n) | 41'h1_0000_0000;
        cyc(1);
        op_cfg_vld = 0;
    endtask

    task automatic beat(input int k);
        vexp_t e;
        global_sram_rd_data = beat_base ^ 128'(k);
        global_sram_rd_data_vld = 1;
        e.lane = k % 16; e.data = global_sram_rd_data; vq.push_back(e);
        cyc(1);
        global_sram_rd_data_vld = 0;
    endtask

    task automatic wait_finish(input string tag);
        int n = 0;
        while (finish !== 1'b1 && n < 40) begin cyc(1); n++; end
        chk(tag, 128'(finish), 128'h1);
    endtask

    initial begin
`ifdef HEAD_KV_CLEAN_EN
        kv_en = 1'b1;
`else
        kv_en = 1'b0;
`endif
        idle_inputs();
        rst_n = 0; clean_kv_cache_user_id = 0; head_mem_addr = 0; head_mem_wdata = 0;
        global_sram_rd_data = 0; vlink_data_in_array = '0; control_state = 0;
        op_cfg = 0; usr_cfg = 12'hABC; model_cfg = 0; pmu_cfg = 0; rc_cfg = 0;
        cyc(3);
        chk("rst_finish", 128'(finish), 0);
        chk("rst_rvld", 128'(head_mem_rvld), 0);
        chk("rst_rdata", 128'(head_mem_rdata), 0);
        chk("rst_vvld", 128'(vlink_data_out_vld_array), 0);
        chk("rst_gwen", 128'(gbus_wen_delay1), 0);
        chk("rst_gaddr", 128'(gbus_addr_delay1), 0);
        rst_n = 1;
        cyc(1);

        // Write then read back, with gbus echo.
        head_mem_addr = 19'h1; head_mem_wdata = 16'hABCD; head_mem_wen = 1;
        cyc(1);
        chk("gbus_wen", 128'(gbus_wen_delay1), 1);
        chk("gbus_addr", 128'(gbus_addr_delay1), 128'h1);
        chk("gbus_wdata", 128'(gbus_wdata_delay1), 128'h0000ABCD);
        head_mem_wen = 0; head_mem_ren = 1; rq.push_back(16'hABCD);
        cyc(1);
        head_mem_ren = 0;
        chk("gbus_wen_low", 128'(gbus_wen_delay1), 0);
        chk("gbus_addr_hold", 128'(gbus_addr_delay1), 128'h1);
        cyc(2);
        chk("rdata_hold", 128'(head_mem_rdata), 128'hABCD);

        // wen and ren together: write only, no rvld.
        head_mem_addr = 19'h2; head_mem_wdata = 16'h1111; head_mem_wen = 1; head_mem_ren = 1;
        cyc(1);
        idle_inputs();
        rd(19'h2, 16'h1111);

        // Out-of-range address: write dropped, read returns 0.
        wr(19'h0, 16'h7777);
        wr(19'h400, 16'h5555);
        rd(19'h400, 16'h0);
        rd(19'h0, 16'h7777);

        // KV region invalidate.
        wr(19'h105, 16'hBEEF);
        clean_kv_cache = 1; clean_kv_cache_user_id = 2'd1;
        cyc(1);
        clean_kv_cache = 0;
        rd(19'h105, kv_en ? 16'h0 : 16'hBEEF);
        head_mem_addr = 19'h106; head_mem_wdata = 16'h1234; head_mem_wen = 1; clean_kv_cache = 1;
        cyc(1);
        idle_inputs();
        rd(19'h106, kv_en ? 16'h0 : 16'h1234);
        wr(19'h107, 16'h4321);
        rd(19'h107, 16'h4321);
        rd(19'h1, 16'hABCD);

        // Lane pass-through while idle, two lanes at once.
        begin
            vexp_t e;
            vlink_data_in_array = '0;
            vlink_data_in_array[0*128 +: 128]  = 128'hA0;
            vlink_data_in_array[15*128 +: 128] = 128'hF15;
            vlink_data_in_vld_array = 16'h8001;
            e.lane = 0;  e.data = 128'hA0;  vq.push_back(e);
            e.lane = 15; e.data = 128'hF15; vq.push_back(e);
            cyc(1);
            vlink_data_in_vld_array = '0;
        end

        // Start with control_state 0 is ignored; beats while idle produce nothing.
        start = 1;
        cyc(1);
        start = 0;
        global_sram_rd_data_vld = 1;
        cyc(1);
        global_sram_rd_data_vld = 0;
        cyc(3);
        chk("cs0_finish", 128'(finish), 0);

        // N=0: finish two edges after the accepting edge; lane pass-through suppressed in RUN.
        control_state = 32'd4; control_state_update = 1; start = 1;
        cyc(1);
        idle_inputs();
        chk("n0_run_finish", 128'(finish), 0);
        vlink_data_in_array[7*128 +: 128] = 128'h77; vlink_data_in_vld_array = 16'h0080;
        cyc(1);
        vlink_data_in_vld_array = '0;
        chk("n0_done_finish", 128'(finish), 0);
        cyc(1);
        chk("n0_finish", 128'(finish), 1);
        cyc(3);
        chk("n0_sticky", 128'(finish), 1);

        // N=3 with a gap between beats.
        set_n(8'd3);
        start = 1;
        cyc(1);
        start = 0;
        chk("n3_finish_clr", 128'(finish), 0);
        beat(0); beat(1); cyc(1); beat(2);
        wait_finish("n3_finish");
        global_sram_rd_data_vld = 1;
        cyc(1);
        global_sram_rd_data_vld = 0;

        // N=17 wraps the lane index back to 0.
        set_n(8'd17);
        start = 1;
        cyc(1);
        start = 0;
        for (int k = 0; k < 17; k++) beat(k);
        wait_finish("n17_finish");

        // Reset mid-RUN aborts without finish.
        set_n(8'd5);
        start = 1;
        cyc(1);
        start = 0;
        beat(0);
        rst_n = 0;
        cyc(1);
        rst_n = 1;
        chk("rst_run_finish", 128'(finish), 0);
        global_sram_rd_data_vld = 1;
        cyc(2);
        global_sram_rd_data_vld = 0;
        cyc(5);
        chk("abort_finish", 128'(finish), 0);

        cyc(2);
        chk("rd_queue_empty", 128'(rq.size()), 0);
        chk("vl_queue_empty", 128'(vq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/attn_head_top.md
# attn_head_top

Single attention-head wrapper. Holds the head-local scratch memory with host read/write access, latches operation/user/model/PMU/rate-control configuration, and sequences global-SRAM beats onto the 16-lane vertical link (vlink). It reports completion through `finish` and mirrors host writes onto a one-cycle-delayed gbus echo. It sits between the global SRAM/config bus and the per-core vlink fabric.

## Interface
- HEAD_MEM_DEPTH, 1024: 16-bit words of head memory (addr[9:0] used).
- LANES, 16: vlink lanes, 128 bits each.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `clean_kv_cache` in 1, `clean_kv_cache_user_id` in 2: KV-region invalidate pulse and user select.
- `head_mem_addr` in 19, `head_mem_wdata` in 16, `head_mem_wen` in 1, `head_mem_ren` in 1: host access.
- `head_mem_rdata` out 16, `head_mem_rvld` out 1: read return.
- `global_sram_rd_data` in 128, `global_sram_rd_data_vld` in 1: input beats.
- `vlink_data_in_array` in 2048, `vlink_data_in_vld_array` in 16: lane i = bits [128i+127:128i].
- `vlink_data_out_array` out 2048, `vlink_data_out_vld_array` out 16.
- `control_state` in 32, `control_state_update` in 1.
- `start` in 1, `finish` out 1.
- `op_cfg_vld`/`op_cfg` in 1/41, `usr_cfg_vld`/`usr_cfg` in 1/12, `model_cfg_vld`/`model_cfg` in 1/30, `pmu_cfg_vld`/`pmu_cfg` in 1/4, `rc_cfg_vld`/`rc_cfg` in 1/84.
- `gbus_addr_delay1` out 19, `gbus_wen_delay1` out 1, `gbus_wdata_delay1` out 32.

## Operation
- Config regs: each latched when its `_vld` is high; held otherwise. `op_cfg[7:0]` = beat target N. usr/model/pmu/rc regs stored only (reserved for downstream).
- `control_state` latched on `control_state_update`. Effective state = incoming value if update is high the same cycle, else the latched value.
- Head memory: addr[18:10] must be 0, otherwise writes are dropped and reads return 0. `wen` has priority over `ren`; a cycle with both performs the write only, and `rvld` stays low.
- KV valid bits: 4 bits, one per user, covering addr[9:8]. A write sets the bit for its region. `clean_kv_cache` clears bit[user_id]. A read from an invalid region returns 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start` when the effective control_state ≠ 0. Entering RUN clears `finish` and the beat/lane counters and captures N.
  - In RUN, each `global_sram_rd_data_vld` beat is written to lane k (k = beat count mod 16, wrapping) with vld[k] pulsing.
  - RUN→DONE when beat count == N, so N=0 means immediate exit.
  - DONE→IDLE sets `finish`.
- `start` during RUN/DONE is ignored.
- Outside RUN, `vlink_data_out` lane i is a registered pass-through of input lane i, qualified by its vld bit.
- In RUN, input-lane pass-through is suppressed; only the beat lane pulses.
- gbus echo: registered copy of host write. `gbus_wen_delay1` = `wen` delayed by 1, `gbus_addr_delay1` = addr, `gbus_wdata_delay1` = {16'h0, wdata}. Addr/data update only on `wen`.

## Timing
- Reset clears all outputs, config regs, FSM (IDLE), counters, and valid bits. Memory contents are not reset.
- Reset mid-RUN aborts to IDLE with `finish` = 0.
- Read latency: 1 cycle. `rvld` is a one-cycle pulse; `rdata` holds until the next read.
- vlink out latency: 1 cycle from input beat or lane.
- `finish` is sticky high from the DONE→IDLE edge until the next accepted `start` or reset. For N=0 it rises 2 cycles after `start`.
- `clean_kv_cache` and a write to the same region in the same cycle: the clean wins, and the bit ends cleared.

## Configuration
- `HEAD_KV_CLEAN_EN` defined: valid bits and `clean_kv_cache` are functional as above.
- `HEAD_KV_CLEAN_EN` undefined: no valid bits; `clean_kv_cache`/user_id are ignored, and reads return stored data.

## Test plan
- Reset, then write 16'hABCD at addr 19'h1 and read it back 1 cycle later → `rdata` = 16'hABCD with a one-cycle `rvld`; gbus echo shows addr 1, data 32'h0000ABCD, and `gbus_wen_delay1` one cycle after `wen`.
- `control_state` = 4 with update and `start` together, op_cfg[7:0] = 0 → `finish` = 1 two cycles later and stays high.
- op_cfg = 41'h3, start, then 3 beats of 128'h1234…6978 → lanes 0, 1, 2 pulse with that data, then `finish`.
- Write addr 19'h105, clean user 1, read addr 19'h105 → 0 (with `HEAD_KV_CLEAN_EN`), otherwise the written data.
- Write to addr 19'h400 → dropped; read returns 0.
- Start with control_state = 0 → FSM stays IDLE and `finish` stays 0.
